// File: rtl/rsbus_frame_generator_pl.sv
// Ring-master frame generator: emits the short/long superframe schedule, measures the ring
// round-trip phase and re-aligns returning traffic through a tapped delay line.

package rsbus_pkg;

  typedef struct packed {
    logic       valid;
    logic [1:0] len;
    logic [1:0] pp;
    logic [3:0] did;
    logic [3:0] rid;
  } rbus_ctrl_t;

  typedef struct packed {
    logic       frm_used;
    logic       frm_owned;
    logic       frm_priority;
    logic       frm_len;
    logic [7:0] addr;
    logic [3:0] sid;
    logic [3:0] rid;
    logic       mem_rd;
    logic       mem_wr;
  } rbus_hdr_t;

  typedef struct packed {
    rbus_hdr_t   header;
    logic [15:0] data;
  } rbus_word_t;

endpackage

module rsbus_frame_generator_pl
  import rsbus_pkg::*;
#(
  parameter int unsigned SHORT_LEN = 2,
  parameter int unsigned LONG_LEN  = 9,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PRIME_SF  = 2,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned ERR_LIMIT = 3,
  localparam int unsigned P  = SHORT_LEN + LONG_LEN,
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sof,
  input  rbus_ctrl_t    i_ctrl,
  input  rbus_word_t    i_bus,
  output logic          o_sof,
  output rbus_ctrl_t    o_ctrl,
  output rbus_word_t    o_bus,
  output logic          o_lock,
  output logic [PW-1:0] o_phase,
  output logic          o_timeout
);

  localparam int unsigned DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = (PRIME_SF > 1) ? $clog2(PRIME_SF) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);

  localparam logic [PW-1:0] ShortPh = PW'(SHORT_LEN);
  localparam logic [PW-1:0] LongPh  = PW'(LONG_LEN);
  localparam logic [PW-1:0] LastPh  = PW'(P - 1);

  typedef enum logic [1:0] {StPrime, StMeasure, StLocked} state_e;

  typedef struct packed {
    rbus_ctrl_t ctrl;
    rbus_word_t bus;
  } entry_t;

  function automatic logic [PW-1:0] add_mod(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PW+1)'(P)) s = s - (PW+1)'(P);
    return s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] tap_of(input logic [PW-1:0] pe);
    logic [PW:0] t;
    t = (PW+1)'(P) - {1'b0, pe};
    return (pe == '0) ? '0 : t[PW-1:0];
  endfunction

  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [SW-1:0] sf_q, sf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [EW-1:0] err_q, err_d;
  logic [EW:0]   err_inc;
  logic          lock_q, lock_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [PW-1:0] tap_q, tap_d;
  logic          timeout_q, timeout_d;
  logic          sof_q;
  logic          sof_loc, long_loc;
  logic [PW-1:0] pe, exp_long;
  logic          sof_match;

  entry_t        dl_q [DEPTH];
  entry_t        ent;
  logic [DW-1:0] tap_idx;

  rbus_ctrl_t    ctrl_d, ctrl_dp_q;
  rbus_word_t    bus_d, bus_dp_q;
  logic          valid_q, used_q, owned_q, prio_q, len_q;

  assign ph_d     = (ph_q == LastPh) ? '0 : ph_q + 1'b1;
  assign sof_loc  = (ph_q == '0) || (ph_q == ShortPh);
  assign long_loc = (ph_q == ShortPh);

  // A long-frame sof returns SHORT_LEN after the short one, so fold it back onto the short phase.
  assign pe        = i_bus.header.frm_len ? add_mod(ph_q, LongPh) : ph_q;
  assign exp_long  = add_mod(phase_q, ShortPh);
  assign sof_match = i_bus.header.frm_len ? (ph_q == exp_long) : (ph_q == phase_q);
  assign err_inc   = {1'b0, err_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    sf_d      = sf_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    lock_d    = lock_q;
    phase_d   = phase_q;
    tap_d     = tap_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StPrime: begin
        lock_d = 1'b0;
        if (ph_q == LastPh) begin
          if (sf_q == SW'(PRIME_SF - 1)) begin
            sf_d    = '0;
            tmo_d   = '0;
            state_d = StMeasure;
          end else begin
            sf_d = sf_q + 1'b1;
          end
        end
      end
      StMeasure: begin
        if (i_sof) begin
          phase_d = pe;
          tap_d   = tap_of(pe);
          err_d   = '0;
          lock_d  = 1'b1;
          state_d = StLocked;
        end else if (tmo_q >= TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          sf_d      = '0;
          state_d   = StPrime;
        end else begin
          tmo_d = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + 1'b1;
        end
      end
      StLocked: begin
        if (i_sof) begin
          if (sof_match) begin
            err_d = '0;
          end else begin
            err_d = err_inc[EW-1:0];
            if (err_inc == (EW+1)'(ERR_LIMIT)) begin
              lock_d  = 1'b0;
              sf_d    = '0;
              state_d = StPrime;
            end
          end
        end
      end
      default: state_d = StPrime;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPrime;
      ph_q      <= '0;
      sf_q      <= '0;
      tmo_q     <= '0;
      err_q     <= '0;
      lock_q    <= 1'b0;
      phase_q   <= '0;
      tap_q     <= '0;
      timeout_q <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      sf_q      <= sf_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      lock_q    <= lock_d;
      phase_q   <= phase_d;
      tap_q     <= tap_d;
      timeout_q <= timeout_d;
      sof_q     <= sof_loc;
    end
  end

  // Delay line carries no reset; its contents are masked until lock.
  always_ff @(posedge clk) begin
    dl_q[0] <= {i_ctrl, i_bus};
    for (int k = 1; k < DEPTH; k++) dl_q[k] <= dl_q[k-1];
  end

  assign tap_idx = DW'(tap_q);
  assign ent     = dl_q[tap_idx];

  always_comb begin
    ctrl_d = ent.ctrl;
    bus_d  = ent.bus;
    if (!lock_q) begin
      ctrl_d.valid               = 1'b0;
      bus_d.header.frm_used      = 1'b0;
      bus_d.header.frm_owned     = 1'b0;
      bus_d.header.frm_priority  = 1'b0;
      bus_d.header.frm_len       = 1'b0;
    end
    if (sof_loc) bus_d.header.frm_len = long_loc;
  end

  always_ff @(posedge clk) begin
    ctrl_dp_q <= ctrl_d;
    bus_dp_q  <= bus_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      used_q  <= 1'b0;
      owned_q <= 1'b0;
      prio_q  <= 1'b0;
      len_q   <= 1'b0;
    end else begin
      valid_q <= ctrl_d.valid;
      used_q  <= bus_d.header.frm_used;
      owned_q <= bus_d.header.frm_owned;
      prio_q  <= bus_d.header.frm_priority;
      len_q   <= bus_d.header.frm_len;
    end
  end

  always_comb begin
    o_ctrl                     = ctrl_dp_q;
    o_ctrl.valid               = valid_q;
    o_bus                      = bus_dp_q;
    o_bus.header.frm_used      = used_q;
    o_bus.header.frm_owned     = owned_q;
    o_bus.header.frm_priority  = prio_q;
    o_bus.header.frm_len       = len_q;
  end

  assign o_sof     = sof_q;
  assign o_lock    = lock_q;
  assign o_phase   = phase_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_rsbus_frame_generator_pl.sv
// Directed bench for rsbus_frame_generator_pl: schedule table, timeout, ring lock at
// several delays, error supervision and asynchronous reset.

module tb_rsbus_frame_generator_pl;
  import rsbus_pkg::*;

  localparam int P     = 11;
  localparam int SHORT = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_sof;
  rbus_ctrl_t i_ctrl;
  rbus_word_t i_bus;
  logic       o_sof;
  rbus_ctrl_t o_ctrl;
  rbus_word_t o_bus;
  logic       o_lock;
  logic [3:0] o_phase;
  logic       o_timeout;

  always #5 clk = ~clk;

  rsbus_frame_generator_pl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sof     (i_sof),
    .i_ctrl    (i_ctrl),
    .i_bus     (i_bus),
    .o_sof     (o_sof),
    .o_ctrl    (o_ctrl),
    .o_bus     (o_bus),
    .o_lock    (o_lock),
    .o_phase   (o_phase),
    .o_timeout (o_timeout)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit ring_on  = 0;
  int ring_d   = 0;
  int ring_from = 0;

  typedef struct {
    logic i_sof;
    logic i_len;
    logic exp_sof;
    logic exp_len;
    logic exp_lock;
  } vec_t;

  vec_t tv [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ring model: a local sof issued at phase s returns on i_sof at phase s+ring_d.
  task automatic drive();
    int phm;
    phm    = cyc % P;
    i_sof  = 1'b0;
    i_ctrl = '0;
    i_bus  = '0;
    if (ring_on && cyc >= ring_from) begin
      if (phm == ring_d % P) begin
        i_sof = 1'b1;
      end else if (phm == (SHORT + ring_d) % P) begin
        i_sof = 1'b1;
        i_bus.header.frm_len = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic run_to_ph(input int ph);
    for (int i = 0; i < P; i++) begin
      if (cyc % P == ph) break;
      drive();
      step();
    end
  endtask

  task automatic wait_lock(input int bound, output int lc);
    lc = -1;
    for (int i = 0; i < bound; i++) begin
      drive();
      if (o_lock) begin
        lc = cyc;
        break;
      end
      step();
    end
    chk("lock_reached", 32'(lc >= 0), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_to, to_hi, lc, t0, n;
    logic was_sof;

    for (int k = 0; k < 16; k++) tv[k] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // sof during PRIME must be ignored
    tv[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sof", 32'(o_sof), 32'd0);
    chk("rst_lock", 32'(o_lock), 32'd0);
    chk("rst_phase", 32'(o_phase), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    chk("rst_valid", 32'(o_ctrl.valid), 32'd0);
    chk("rst_hdr", 32'({o_bus.header.frm_used, o_bus.header.frm_owned,
                        o_bus.header.frm_priority, o_bus.header.frm_len}), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // Free-running schedule: sof pulses 2 then 9 cycles apart, frm_len forced per frame.
    for (int k = 0; k < 16; k++) begin
      drive();
      i_sof                = tv[k].i_sof;
      i_bus.header.frm_len = tv[k].i_len;
      chk("sched_sof", 32'(o_sof), 32'(tv[k].exp_sof));
      chk("sched_len", 32'(o_bus.header.frm_len), 32'(tv[k].exp_len));
      chk("sched_lock", 32'(o_lock), 32'(tv[k].exp_lock));
      chk("sched_valid", 32'(o_ctrl.valid), 32'd0);
      step();
    end

    // MEASURE starts at cycle 22; with no return it times out TIMEOUT cycles later.
    first_to = -1;
    to_hi    = 0;
    while (cyc < 1100) begin
      drive();
      if (o_timeout) begin
        if (first_to < 0) first_to = cyc;
        to_hi++;
      end
      step();
    end
    chk("timeout_cycle", 32'(first_to), 32'(22 + 1024));
    chk("timeout_width", 32'(to_hi), 32'd1);
    chk("timeout_nolock", 32'(o_lock), 32'd0);

    // Ring delay 5: PRIME restarted at 1046, MEASURE from 1067; first sof at 1105 (ph 5).
    ring_on   = 1;
    ring_d    = 5;
    ring_from = 0;
    wait_lock(200, lc);
    chk("d5_lock_cycle", 32'(lc), 32'd1106);
    chk("d5_phase", 32'(o_phase), 32'd5);
    chk("d5_tap", 32'(dut.tap_q), 32'd6);
    run(22);
    chk("d5_hold_lock", 32'(o_lock), 32'd1);
    chk("d5_err", 32'(dut.err_q), 32'd0);

    // Injected word reaches the output tap+2 cycles later.
    run_to_ph(0);
    drive();
    i_ctrl.valid          = 1'b1;
    i_ctrl.did            = 4'hA;
    i_bus.data            = 16'hBEEF;
    i_bus.header.frm_used = 1'b1;
    t0 = cyc;
    step();
    while (cyc < t0 + 7) begin
      drive();
      step();
    end
    chk("inj_before", 32'(o_ctrl.valid), 32'd0);
    drive();
    step();
    chk("inj_valid", 32'(o_ctrl.valid), 32'd1);
    chk("inj_data", 32'(o_bus.data), 32'hBEEF);
    chk("inj_did", 32'(o_ctrl.did), 32'hA);
    chk("inj_used", 32'(o_bus.header.frm_used), 32'd1);
    drive();
    step();
    chk("inj_after", 32'(o_ctrl.valid), 32'd0);

    // Delay jumps to 7: three misaligned sofs drop lock, then relock at pe=7.
    run_to_ph(0);
    ring_d = 7;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      drive();
      was_sof = i_sof;
      step();
      if (was_sof) begin
        n++;
        if (n < 3) begin
          chk("d7_err", 32'(dut.err_q), 32'(n));
          chk("d7_still_locked", 32'(o_lock), 32'd1);
        end else begin
          chk("d7_drop", 32'(o_lock), 32'd0);
          break;
        end
      end
    end
    chk("d7_sof_count", 32'(n), 32'd3);
    wait_lock(200, lc);
    chk("d7_phase", 32'(o_phase), 32'd7);
    chk("d7_tap", 32'(dut.tap_q), 32'd4);

    // Single spurious sof: err 1 then back to 0 on the next aligned sof.
    run(11);
    run_to_ph(0);
    drive();
    i_sof = 1'b1;
    step();
    chk("spur_err1", 32'(dut.err_q), 32'd1);
    chk("spur_lock1", 32'(o_lock), 32'd1);
    for (int i = 0; i < P; i++) begin
      drive();
      was_sof = i_sof;
      step();
      if (was_sof) break;
    end
    chk("spur_err0", 32'(dut.err_q), 32'd0);
    chk("spur_lock0", 32'(o_lock), 32'd1);

    // Asynchronous reset while locked, right in an o_sof cycle.
    for (int i = 0; i < P; i++) begin
      if (o_sof) break;
      drive();
      step();
    end
    chk("pre_rst_sof", 32'(o_sof), 32'd1);
    chk("pre_rst_lock", 32'(o_lock), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lock", 32'(o_lock), 32'd0);
    chk("arst_sof", 32'(o_sof), 32'd0);
    chk("arst_valid", 32'(o_ctrl.valid), 32'd0);
    chk("arst_phase", 32'(o_phase), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    cyc       = 0;
    ring_d    = 13;
    ring_from = 25;

    // Delay 13: first return seen is the long sof at ph 4 -> pe 2, tap 9.
    run(1);
    chk("post_rst_sof", 32'(o_sof), 32'd1);
    wait_lock(100, lc);
    chk("d13_lock_cycle", 32'(lc), 32'd27);
    chk("d13_phase", 32'(o_phase), 32'd2);
    chk("d13_tap", 32'(dut.tap_q), 32'd9);
    run(33);
    chk("d13_hold_lock", 32'(o_lock), 32'd1);
    chk("d13_err", 32'(dut.err_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
